// File: rtl/brief_pkg.sv
// Shared constants and sizing helpers for the binary-descriptor builder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package brief_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_LANES     = 8;
    localparam int DEF_DESC_BITS = 256;

    // Number of beats that make up one descriptor.
    function automatic int brief_beats(input int desc_bits, input int lanes);
        return desc_bits / lanes;
    endfunction

    // Width of the beat counter; never narrower than one bit.
    function automatic int brief_cnt_w(input int desc_bits, input int lanes);
        int beats;
        beats = desc_bits / lanes;
        return (beats < 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/brief_lane_cmp.sv
// LANES parallel unsigned strict-less-than comparators (x < y) for one beat.
// Latency: purely combinational.
// Backpressure: none; evaluates whatever is on its inputs.
// Ports: x, y (LANES packed samples), bits (one test bit per lane),
//        pop (popcount of bits, only when BRIEF_WEIGHT_EN is defined).
module brief_lane_cmp
    import brief_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic [LANES*DATA_W-1:0]     x,
    input  logic [LANES*DATA_W-1:0]     y,
`ifdef BRIEF_WEIGHT_EN
    output logic [$clog2(LANES+1)-1:0]  pop,
`endif
    output logic [LANES-1:0]            bits
);

    always_comb begin
        bits = '0;
        for (int i = 0; i < LANES; i++) begin
            // Equal samples deliberately give 0.
            bits[i] = (x[i*DATA_W +: DATA_W] < y[i*DATA_W +: DATA_W]);
        end
    end

`ifdef BRIEF_WEIGHT_EN
    localparam int PW = $clog2(LANES+1);

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(bits[i]);
        end
    end
`endif

endmodule

// File: rtl/brief_descriptor.sv
// Streaming builder: LANES compare bits per beat packed into a DESC_BITS descriptor.
// Latency: descriptor valid one cycle after the final beat; one beat per cycle sustained.
// Backpressure: in_ready drops only when the final beat would overwrite an unconsumed descriptor.
// Ports: clk/rst (async active-high), in_valid/in_ready/in_x/in_y/in_last beat input,
//        desc_valid/desc_ready/desc_out descriptor output, err framing-error pulse,
//        desc_weight popcount of desc_out (only when BRIEF_WEIGHT_EN is defined).
module brief_descriptor
    import brief_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LANES     = DEF_LANES,
    parameter int DESC_BITS = DEF_DESC_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_W-1:0]        in_x,
    input  logic [LANES*DATA_W-1:0]        in_y,
    input  logic                           in_last,
    output logic                           desc_valid,
    input  logic                           desc_ready,
    output logic [DESC_BITS-1:0]           desc_out,
`ifdef BRIEF_WEIGHT_EN
    output logic [$clog2(DESC_BITS+1)-1:0] desc_weight,
`endif
    output logic                           err
);

    localparam int BEATS = brief_beats(DESC_BITS, LANES);
    localparam int CNT_W = brief_cnt_w(DESC_BITS, LANES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

    if ((DESC_BITS % LANES) != 0 || BEATS < 2) begin : g_bad_cfg
        $error("brief_descriptor: DESC_BITS must be a multiple of LANES with at least 2 beats");
    end

    logic [CNT_W-1:0]     beat_cnt;
    logic [DESC_BITS-1:0] acc;
    logic [DESC_BITS-1:0] acc_merged;
    logic [LANES-1:0]     beat_bits;
    logic                 last_slot;
    logic                 accept;
    logic                 frame_err;
    logic                 final_beat;

`ifdef BRIEF_WEIGHT_EN
    localparam int WW = $clog2(DESC_BITS+1);
    logic [$clog2(LANES+1)-1:0] beat_pop;
    logic [WW-1:0]              wacc;
    logic [WW-1:0]              wacc_next;
`endif

    brief_lane_cmp #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_cmp (
        .x      (in_x),
        .y      (in_y),
`ifdef BRIEF_WEIGHT_EN
        .pop    (beat_pop),
`endif
        .bits   (beat_bits)
    );

    assign last_slot = (beat_cnt == LAST_BEAT);

    // Depends only on registered state and desc_ready, never on in_valid.
    assign in_ready   = !(desc_valid && last_slot && !desc_ready);
    assign accept     = in_valid && in_ready;
    assign frame_err  = accept && (in_last != last_slot);
    assign final_beat = accept && in_last && last_slot;

    // acc with the current beat's slice written in; feeds both acc and desc_out.
    always_comb begin
        acc_merged = acc;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == CNT_W'(b)) begin
                acc_merged[b*LANES +: LANES] = beat_bits;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            acc        <= '0;
            desc_out   <= '0;
            desc_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= frame_err;

            if (frame_err) begin
                // Drop the partial descriptor; pending output is untouched.
                beat_cnt <= '0;
                acc      <= '0;
            end else if (final_beat) begin
                beat_cnt <= '0;
                acc      <= '0;
                desc_out <= acc_merged;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                acc      <= acc_merged;
            end

            // A completing descriptor wins over a same-cycle consume.
            if (final_beat) begin
                desc_valid <= 1'b1;
            end else if (desc_ready) begin
                desc_valid <= 1'b0;
            end
        end
    end

`ifdef BRIEF_WEIGHT_EN
    assign wacc_next = wacc + WW'(beat_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wacc        <= '0;
            desc_weight <= '0;
        end else if (frame_err) begin
            wacc <= '0;
        end else if (final_beat) begin
            wacc        <= '0;
            desc_weight <= wacc_next;
        end else if (accept) begin
            wacc <= wacc_next;
        end
    end
`endif

endmodule

// File: tb/tb_brief_descriptor.sv
// Self-checking bench for brief_descriptor (DATA_W=8, LANES=8, DESC_BITS=32).
// Latency: n/a.
// Backpressure: n/a.
module tb_brief_descriptor;

    localparam int DATA_W    = 8;
    localparam int LANES     = 8;
    localparam int DESC_BITS = 32;
    localparam int BEATS     = DESC_BITS / LANES;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x;
    logic [63:0] in_y;
    logic        in_last;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_out;
    logic        err;
`ifdef BRIEF_WEIGHT_EN
    logic [5:0]  desc_weight;
`endif

    brief_descriptor #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .DESC_BITS (DESC_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_last     (in_last),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_out    (desc_out),
`ifdef BRIEF_WEIGHT_EN
        .desc_weight (desc_weight),
`endif
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][63:0] x;
        logic [3:0][63:0] y;
        logic [31:0]      exp_desc;
        logic [5:0]       exp_w;
    } vec_t;

    vec_t vecs [5];

    // Behavioural model state: beats of the descriptor in progress and
    // descriptors that have been completed but not yet consumed.
    logic [63:0] cur_x [$];
    logic [63:0] cur_y [$];
    logic [31:0] expq  [$];
    int          expw  [$];
    bit          err_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic send_beat(input logic [63:0] x, input logic [63:0] y, input logic last);
        in_x     = x;
        in_y     = y;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int e);
        for (int b = 0; b < BEATS; b++) begin
            send_beat(vecs[e].x[b], vecs[e].y[b], b == BEATS-1);
        end
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_desc_valid"}, desc_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_desc_out"}, desc_out, 0);
`ifdef BRIEF_WEIGHT_EN
        chk({tag, "_weight"}, desc_weight, 0);
`endif
    endtask

    function automatic logic [31:0] model_desc();
        logic [31:0] d;
        logic [63:0] bx;
        logic [63:0] by;
        d = '0;
        for (int b = 0; b < BEATS; b++) begin
            bx = cur_x[b];
            by = cur_y[b];
            for (int i = 0; i < LANES; i++) begin
                d[b*LANES + i] = (int'(bx[i*8 +: 8]) < int'(by[i*8 +: 8]));
            end
        end
        return d;
    endfunction

    function automatic int ones(input logic [31:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(d[i]);
        return n;
    endfunction

    initial begin
        // ---------------- vector table ----------------
        vecs[0].x = '0;
        vecs[0].y = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[0].exp_desc = 32'hFFFF_FFFF;
        vecs[0].exp_w = 6'd32;

        vecs[1].x = {4{64'h8080_8080_8080_8080}};
        vecs[1].y = {4{64'h8080_8080_8080_8080}};
        vecs[1].x[0][7:0] = 8'd3;
        vecs[1].y[0][7:0] = 8'd4;
        vecs[1].exp_desc = 32'h0000_0001;
        vecs[1].exp_w = 6'd1;

        vecs[2].x = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[2].y = '0;
        vecs[2].exp_desc = 32'h0000_0000;
        vecs[2].exp_w = 6'd0;

        vecs[3].x = {4{64'h5555_5555_5555_5555}};
        vecs[3].y = {4{64'h5555_5555_5555_5555}};
        vecs[3].exp_desc = 32'h0000_0000;
        vecs[3].exp_w = 6'd0;

        // x = lane index, y = beat index: bit set where lane < beat.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                vecs[4].x[b][i*8 +: 8] = 8'(i);
                vecs[4].y[b][i*8 +: 8] = 8'(b);
            end
        end
        vecs[4].exp_desc = 32'h0703_0100;
        vecs[4].exp_w = 6'd6;

        // ---------------- reset ----------------
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_x = '0;
        in_y = '0;
        desc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("por_desc_valid", desc_valid, 0);
        chk("por_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        do_reset("idle_rst");

        // ---------------- table-driven, back-to-back ----------------
        desc_ready = 1'b1;
        for (int e = 0; e < 5; e++) begin
            send_vec(e);
            chk($sformatf("tbl%0d_valid", e), desc_valid, 1);
            chk($sformatf("tbl%0d_desc", e), desc_out, vecs[e].exp_desc);
            chk($sformatf("tbl%0d_err", e), err, 0);
`ifdef BRIEF_WEIGHT_EN
            chk($sformatf("tbl%0d_weight", e), desc_weight, vecs[e].exp_w);
`endif
        end
        @(posedge clk);
        #1;
        chk("tbl_drain_valid", desc_valid, 0);

        // ---------------- backpressure ----------------
        desc_ready = 1'b0;
        send_vec(0);
        chk("bp_a_valid", desc_valid, 1);
        chk("bp_a_desc", desc_out, 32'hFFFF_FFFF);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("bp_rdy_b%0d", b), in_ready, 1);
            send_beat(vecs[4].x[b], vecs[4].y[b], 1'b0);
        end
        chk("bp_block_rdy", in_ready, 0);
        in_x = vecs[4].x[3];
        in_y = vecs[4].y[3];
        in_last = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hold_rdy", in_ready, 0);
        chk("bp_hold_desc", desc_out, 32'hFFFF_FFFF);
        chk("bp_hold_valid", desc_valid, 1);
        desc_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_b_valid", desc_valid, 1);
        chk("bp_b_desc", desc_out, 32'h0703_0100);
        @(posedge clk);
        #1;
        chk("bp_b_consumed", desc_valid, 0);

        // ---------------- framing: early last ----------------
        send_beat(vecs[0].x[0], vecs[0].y[0], 1'b0);
        send_beat(vecs[0].x[1], vecs[0].y[1], 1'b1);
        chk("frm_early_err", err, 1);
        chk("frm_early_valid", desc_valid, 0);
        @(posedge clk);
        #1;
        chk("frm_early_err_clear", err, 0);
        send_vec(4);
        chk("frm_recover_valid", desc_valid, 1);
        chk("frm_recover_desc", desc_out, 32'h0703_0100);

        // ---------------- framing: missing last on final slot ----------------
        for (int b = 0; b < BEATS; b++) begin
            send_beat(vecs[1].x[b], vecs[1].y[b], 1'b0);
        end
        chk("frm_nolast_err", err, 1);
        chk("frm_nolast_valid", desc_valid, 0);
        send_vec(1);
        chk("frm_nolast_recover", desc_out, 32'h0000_0001);

        // ---------------- mid-stream reset ----------------
        @(posedge clk);
        #1;
        send_beat(vecs[0].x[0], vecs[0].y[0], 1'b0);
        send_beat(vecs[0].x[1], vecs[0].y[1], 1'b0);
        do_reset("mid_rst");
        send_vec(1);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_valid", desc_valid, 1);
        chk("mid_rst_desc", desc_out, 32'h0000_0001);
`ifdef BRIEF_WEIGHT_EN
        chk("mid_rst_weight", desc_weight, 1);
`endif

        // ---------------- randomized against the model ----------------
        @(posedge clk);
        #1;
        do_reset("rnd_rst");
        cur_x.delete();
        cur_y.delete();
        expq.delete();
        expw.delete();
        err_exp = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [63:0] rx;
            logic [63:0] ry;
            bit          last_ok;
            bit          exp_rdy;
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) == 0) ry[i*8 +: 8] = rx[i*8 +: 8];
            end
            last_ok    = (cur_x.size() == BEATS-1);
            in_x       = rx;
            in_y       = ry;
            in_valid   = ($urandom_range(0, 3) != 0);
            desc_ready = ($urandom_range(0, 1) != 0);
            in_last    = ($urandom_range(0, 15) == 0) ? !last_ok : last_ok;
            #1;
            exp_rdy = !(expq.size() != 0 && cur_x.size() == BEATS-1 && !desc_ready);
            chk("rnd_in_ready", in_ready, exp_rdy);
            if (expq.size() != 0 && desc_ready) begin
                void'(expq.pop_front());
                void'(expw.pop_front());
            end
            err_exp = 1'b0;
            if (in_valid && exp_rdy) begin
                if (in_last != (cur_x.size() == BEATS-1)) begin
                    err_exp = 1'b1;
                    cur_x.delete();
                    cur_y.delete();
                end else begin
                    cur_x.push_back(rx);
                    cur_y.push_back(ry);
                    if (cur_x.size() == BEATS) begin
                        expq.push_back(model_desc());
                        expw.push_back(ones(model_desc()));
                        cur_x.delete();
                        cur_y.delete();
                    end
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_err", err, err_exp);
            chk("rnd_desc_valid", desc_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                chk("rnd_desc_out", desc_out, expq[0]);
`ifdef BRIEF_WEIGHT_EN
                chk("rnd_weight", desc_weight, 6'(expw[0]));
`endif
            end
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
